// File: rtl/sipo_rx_pkg.sv
// Shared definitions for the serial-to-parallel receiver: FSM state encodings.
package sipo_pkg;
   localparam logic [0:0] COLLECT = 1'b0;
   localparam logic [0:0] STALL   = 1'b1;
endpackage

// File: rtl/sipo_rx_if.sv
// Serial-in / parallel-out handshake bundle; slave is the receiver, master drives it.
interface sipo_rx_if #(parameter int WIDTH = 4);
   logic             data_i;
   logic             valid_i;
   logic             ready_o;
   logic             flush_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             ready_i;
   logic             err_o;

   modport slave (
      input  data_i, valid_i, flush_i, ready_i,
      output ready_o, data_o, valid_o, err_o
   );

   modport master (
      output data_i, valid_i, flush_i, ready_i,
      input  ready_o, data_o, valid_o, err_o
   );
endinterface

// File: rtl/sipo_rx.sv
// Assembles MSB-first serial bits into WIDTH-bit words with a one-deep output
// register; a completed word that cannot be delivered is parked in the shift register.
module sipo_rx
   import sipo_pkg::*;
#(
   parameter int WIDTH = 4
) (
   input  logic     clk_rx_in,
   input  logic     rst,
   sipo_rx_if.slave bus
);
   localparam int            CW   = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   logic [0:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] shreg;
   logic             run;
   logic             accept;
   logic             last_bit;
   logic             drain;
   logic             out_free;

   // run holds ready_o low until the first edge after reset is released
   assign bus.ready_o = run & (state == COLLECT);
   assign accept      = bus.valid_i & bus.ready_o & ~bus.flush_i;
   assign last_bit    = accept & (cnt == LAST);
   assign drain       = bus.valid_o & bus.ready_i;
   assign out_free    = ~bus.valid_o | bus.ready_i;

   always_ff @(posedge clk_rx_in or posedge rst) begin
      if (rst) run <= 1'b0;
      else     run <= 1'b1;
   end

   always_ff @(posedge clk_rx_in or posedge rst) begin
      if (rst)                            cnt <= '0;
      else if (bus.flush_i)               cnt <= '0;
      else if (state == STALL && drain)   cnt <= '0;
      else if (accept)                    cnt <= last_bit ? '0 : cnt + 1'b1;
   end

   always_ff @(posedge clk_rx_in or posedge rst) begin
      if (rst)              shreg <= '0;
      else if (bus.flush_i) shreg <= '0;
      else if (accept)      shreg <= {shreg[WIDTH-2:0], bus.data_i};
   end

   // A parked word takes priority; a flush discards it, so only the drain remains.
   always_ff @(posedge clk_rx_in or posedge rst) begin
      if (rst) begin
         bus.data_o  <= '0;
         bus.valid_o <= 1'b0;
      end else if (state == STALL && drain && !bus.flush_i) begin
         bus.data_o  <= shreg;
         bus.valid_o <= 1'b1;
      end else if (last_bit && out_free) begin
         bus.data_o  <= {shreg[WIDTH-2:0], bus.data_i};
         bus.valid_o <= 1'b1;
      end else if (drain) begin
         bus.valid_o <= 1'b0;
      end
   end

   always_ff @(posedge clk_rx_in or posedge rst) begin
      if (rst)                                              state <= COLLECT;
      else if (bus.flush_i)                                 state <= COLLECT;
      else if (state == COLLECT && last_bit && !out_free)   state <= STALL;
      else if (state == STALL && drain)                     state <= COLLECT;
   end

   always_ff @(posedge clk_rx_in or posedge rst) begin
      if (rst)                               bus.err_o <= 1'b0;
      else if (bus.flush_i)                  bus.err_o <= 1'b0;
      else if (bus.valid_i && !bus.ready_o)  bus.err_o <= 1'b1;
   end
endmodule

// File: tb/tb_sipo_rx.sv
// Directed bench for sipo_rx: expected words are queued as stimulus completes
// them and compared when the receiver hands them downstream.
module tb_sipo_rx;
   import sipo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   int   delivered = 0;
   logic [3:0] exp_q[$];

   sipo_rx_if #(.WIDTH(4)) bus();

   sipo_rx #(.WIDTH(4)) dut (
      .clk_rx_in (clk),
      .rst       (rst),
      .bus       (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Downstream side: a word is consumed at the next edge whenever valid_o && ready_i.
   always @(negedge clk) begin
      if (!rst && bus.valid_o && bus.ready_i) begin
         check("word_expected", 32'(exp_q.size() != 0), 32'd1);
         if (exp_q.size() != 0) begin
            logic [3:0] w;
            w = exp_q.pop_front();
            check("word_data", 32'(bus.data_o), 32'(w));
            delivered++;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bit(input logic b);
      bus.valid_i = 1'b1;
      bus.data_i  = b;
      tick();
      bus.valid_i = 1'b0;
      bus.data_i  = 1'b0;
   endtask

   task automatic send_word(input logic [3:0] w, input bit expect_out);
      for (int i = 3; i >= 0; i--) begin
         if (i == 0 && expect_out) exp_q.push_back(w);
         send_bit(w[i]);
      end
   endtask

   initial begin
      int d0;
      bus.data_i  = 1'b0;
      bus.valid_i = 1'b0;
      bus.flush_i = 1'b0;
      bus.ready_i = 1'b0;

      // Reset state
      #2;
      check("rst_data_o",  32'(bus.data_o),  32'd0);
      check("rst_valid_o", 32'(bus.valid_o), 32'd0);
      check("rst_err_o",   32'(bus.err_o),   32'd0);
      check("rst_ready_o", 32'(bus.ready_o), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("ready_after_rst", 32'(bus.ready_o), 32'd1);

      // Basic assembly: 1,0,1,1 -> 4'b1011 for exactly one cycle
      bus.ready_i = 1'b1;
      send_word(4'b1011, 1'b1);
      check("basic_valid", 32'(bus.valid_o), 32'd1);
      check("basic_data",  32'(bus.data_o),  32'hB);
      tick();
      check("basic_valid_drop", 32'(bus.valid_o), 32'd0);

      // Backpressure: A held in output, 5 parked in shift register
      bus.ready_i = 1'b0;
      send_word(4'hA, 1'b1);
      check("bp_first_valid", 32'(bus.valid_o), 32'd1);
      check("bp_ready_open",  32'(bus.ready_o), 32'd1);
      send_word(4'h5, 1'b1);
      check("bp_stall_state", 32'(dut.state),   32'(STALL));
      check("bp_ready_low",   32'(bus.ready_o), 32'd0);
      check("bp_hold_data",   32'(bus.data_o),  32'hA);
      tick();
      check("bp_hold_stable", 32'(bus.data_o),  32'hA);
      bus.ready_i = 1'b1;
      tick();
      check("bp_second_data",  32'(bus.data_o),  32'h5);
      check("bp_second_valid", 32'(bus.valid_o), 32'd1);
      check("bp_ready_back",   32'(bus.ready_o), 32'd1);
      tick();
      check("bp_drained", 32'(bus.valid_o), 32'd0);

      // Overflow flag while stalled, then flush discards the parked word
      bus.ready_i = 1'b0;
      send_word(4'hC, 1'b1);
      send_word(4'h3, 1'b0);
      check("ovf_ready_low", 32'(bus.ready_o), 32'd0);
      send_bit(1'b1);
      check("ovf_err_set",   32'(bus.err_o),  32'd1);
      check("ovf_data_held", 32'(bus.data_o), 32'hC);
      check("ovf_shreg_held", 32'(dut.shreg), 32'h3);
      bus.flush_i = 1'b1;
      tick();
      bus.flush_i = 1'b0;
      check("flush_err_clr",  32'(bus.err_o),   32'd0);
      check("flush_cnt_clr",  32'(dut.cnt),     32'd0);
      check("flush_ready",    32'(bus.ready_o), 32'd1);
      check("flush_keeps_out", 32'(bus.valid_o), 32'd1);
      bus.ready_i = 1'b1;
      tick();
      check("flush_out_drained", 32'(bus.valid_o), 32'd0);

      // Gaps and flush with a simultaneous bit: only 4'h6 may appear
      send_bit(1'b1);
      tick();
      tick();
      send_bit(1'b1);
      tick();
      bus.flush_i = 1'b1;
      send_bit(1'b1);
      bus.flush_i = 1'b0;
      check("gap_flush_cnt", 32'(dut.cnt), 32'd0);
      send_word(4'h6, 1'b1);
      check("gap_data",  32'(bus.data_o),  32'h6);
      check("gap_valid", 32'(bus.valid_o), 32'd1);
      tick();

      // Reset mid-word
      send_bit(1'b1);
      send_bit(1'b0);
      rst = 1'b1;
      #1;
      check("mid_rst_data",  32'(bus.data_o),  32'd0);
      check("mid_rst_valid", 32'(bus.valid_o), 32'd0);
      check("mid_rst_err",   32'(bus.err_o),   32'd0);
      check("mid_rst_ready", 32'(bus.ready_o), 32'd0);
      tick();
      rst = 1'b0;
      tick();
      check("mid_rst_ready_back", 32'(bus.ready_o), 32'd1);
      send_word(4'h9, 1'b1);
      check("mid_rst_word", 32'(bus.data_o), 32'h9);
      tick();

      // Back-to-back streaming
      d0 = delivered;
      for (int w = 0; w < 3; w++) begin
         logic [3:0] word;
         word = (w == 0) ? 4'h3 : (w == 1) ? 4'hC : 4'hF;
         for (int i = 3; i >= 0; i--) begin
            if (i == 0) exp_q.push_back(word);
            check("stream_ready", 32'(bus.ready_o), 32'd1);
            send_bit(word[i]);
         end
      end
      tick();
      tick();
      check("stream_count", 32'(delivered - d0), 32'd3);
      check("stream_no_err", 32'(bus.err_o), 32'd0);
      check("queue_empty", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/sipo_rx.md
SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 4, meaning word length in bits (legal range 2..32).
REQ-002 SHALL provide port clk_rx_in  input  1  receive clock; all state updates on its rising edge.
REQ-003 SHALL provide port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL provide port data_i  input  1  serial data bit, MSB of each word first.
REQ-005 SHALL provide port valid_i  input  1  data_i carries a valid bit this cycle.
REQ-006 SHALL provide port ready_o  output  1  block accepts a serial bit this cycle.
REQ-007 SHALL provide port flush_i  input  1  synchronous discard of any partial word.
REQ-008 SHALL provide port data_o  output  WIDTH  assembled parallel word.
REQ-009 SHALL provide port valid_o  output  1  data_o holds an undelivered word.
REQ-010 SHALL provide port ready_i  input  1  downstream accepts data_o this cycle.
REQ-011 SHALL provide port err_o  output  1  sticky flag: a bit was offered while ready_o was low.

Function
REQ-012 SHALL accept a bit only when valid_i && ready_o at a clock edge; shift register becomes {shreg[WIDTH-2:0], data_i}.
REQ-013 SHALL keep a bit counter of $clog2(WIDTH)+1 bits, 0..WIDTH-1, incremented per accepted bit and wrapped to 0 on the WIDTH-th bit.
REQ-014 SHALL run a two-state FSM: COLLECT (receiving bits) and STALL (word complete, output register occupied).
REQ-015 SHALL, on acceptance of the WIDTH-th bit with output register empty or draining this cycle (valid_o && ready_i), load the completed word into data_o and assert valid_o on the next edge (latency 1 cycle after last bit), remaining in COLLECT.
REQ-016 SHALL, on acceptance of the WIDTH-th bit while valid_o high and ready_i low, hold the word in the shift register and enter STALL.
REQ-017 SHALL drive ready_o = 1 in COLLECT and 0 in STALL and during reset; ready_o SHALL be a registered/state-decoded signal, not combinationally dependent on valid_i.
REQ-018 SHALL, in STALL, on valid_o && ready_i, move the held word into data_o, keep valid_o high, clear the counter and return to COLLECT on the next edge.
REQ-019 SHALL, on valid_o && ready_i with no new word arriving, deassert valid_o on the next edge; data_o SHALL remain stable whenever valid_o is high and ready_i low.
REQ-020 SHALL set err_o on any edge where valid_i is high and ready_o is low; the bit is dropped and state unchanged.
REQ-021 SHALL, on flush_i high, clear the counter and shift register, clear err_o, and return to COLLECT; flush_i SHALL NOT affect data_o/valid_o, and a word held in STALL SHALL be discarded.
REQ-022 SHALL give flush_i priority over a simultaneous accepted bit (the bit is discarded).
REQ-023 SHALL, when valid_i is low, hold counter and shift register unchanged (gaps between bits allowed).

Reset
REQ-024 SHALL, on rst high, asynchronously force data_o=0, valid_o=0, err_o=0, counter=0, shift register=0, FSM=COLLECT, with ready_o=0 while rst is high.
REQ-025 SHALL drive ready_o=1 from the first edge after rst deasserts; a partial word in progress at reset SHALL be lost.

Structure
REQ-026 SHALL place the FSM state encodings (COLLECT=1'b0, STALL=1'b1) in the shared package sipo_pkg; WIDTH remains a module parameter.
REQ-027 SHALL be implemented as a single module with no sub-modules; counter, shift register, output register and FSM in separate always blocks.

Verification
REQ-028 SHALL verify basic assembly: WIDTH=4, ready_i=1, bits 1,0,1,1 on consecutive cycles -> data_o=4'b1011, valid_o high for exactly 1 cycle, 1 cycle after the 4th bit.
REQ-029 SHALL verify backpressure: ready_i=0, send 4'hA then 4'h5 -> valid_o holds data_o=4'hA, FSM enters STALL, ready_o=0; raise ready_i -> 4'hA delivered, then 4'h5, ready_o returns to 1.
REQ-030 SHALL verify overflow flag: in STALL drive valid_i=1 with data_i=1 -> err_o=1, held word unchanged; flush_i pulse -> err_o=0, counter=0.
REQ-031 SHALL verify gaps and flush: bits 1,1 with idle cycles between, then flush_i with a simultaneous bit, then bits 0,1,1,0 -> only data_o=4'h6 appears.
REQ-032 SHALL verify reset mid-word: assert rst after 2 of 4 bits -> all outputs 0 immediately; after release, bits 1,0,0,1 -> data_o=4'h9.
REQ-033 SHALL verify back-to-back streaming: 3 words 4'h3, 4'hC, 4'hF with continuous valid_i and ready_i=1 -> three valid_o pulses, no err_o, ready_o never low.
